// File: rtl/fifo19_to_ll8.sv
// fifo19_to_ll8: unpacks 19-bit FIFO words {occ,eof,sof,hi,lo} into an 8-bit
// LocalLink byte stream and checks the packet framing of the incoming words.
// Build option: define FIFO19_TO_LL8_STATS_EN to add the packet and byte counters.
module fifo19_to_ll8 #(
    parameter int unsigned DROP_ORPHANS = 1,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clear,
    input  logic [18:0]          f19_data,
    input  logic                 f19_src_rdy_i,
    output logic                 f19_dst_rdy_o,
    output logic [7:0]           ll_data,
    output logic                 ll_sof,
    output logic                 ll_eof,
    output logic                 ll_error,
    output logic                 ll_src_rdy,
    input  logic                 ll_dst_rdy,
    output logic                 frame_err,
    output logic [CNT_WIDTH-1:0] err_count,
    output logic [CNT_WIDTH-1:0] pkt_count,
    output logic [31:0]          byte_count
);

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned BYTE_CNT_W = 32;
    localparam bit          DROP_EN    = (DROP_ORPHANS != 0);

    typedef struct packed {
        logic              occ;
        logic              eof;
        logic              sof;
        logic [BYTE_W-1:0] hi;
        logic [BYTE_W-1:0] lo;
    } f19_word_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HI    = 2'd1,
        LO    = 2'd2,
        DROP  = 2'd3
    } state_t;

    f19_word_t         in_word;
    state_t            state;
    logic [BYTE_W-1:0] hold_lo;
    logic              hold_eof;
    logic              hold_tail;
    logic              in_pkt;

    logic xfer_c;
    logic last_c;
    logic accept_c;
    logic in_pkt_nxt_c;
    logic orphan_c;
    logic missing_eof_c;

    assign in_word = f19_word_t'(f19_data);

    // Handshake: a new word may enter when nothing is held or the held word's last byte leaves now.
    assign xfer_c        = ll_src_rdy & ll_dst_rdy;
    assign last_c        = (state == LO) | ((state == HI) & hold_tail);
    assign f19_dst_rdy_o = (state == EMPTY) | (xfer_c & last_c);
    assign accept_c      = f19_src_rdy_i & f19_dst_rdy_o;

    // Packet membership as it will be after this cycle's byte transfer; used to classify a new word.
    always_comb begin
        in_pkt_nxt_c = in_pkt;
        if (xfer_c) begin
            if (ll_eof) begin
                in_pkt_nxt_c = 1'b0;
            end else if (ll_sof) begin
                in_pkt_nxt_c = 1'b1;
            end
        end
    end

    assign orphan_c      = accept_c & ~in_word.sof & ~in_pkt_nxt_c;
    assign missing_eof_c = accept_c &  in_word.sof &  in_pkt_nxt_c;

    // Byte-emission FSM; the LocalLink outputs are loaded directly from the incoming or held word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= EMPTY;
            hold_lo    <= '0;
            hold_eof   <= 1'b0;
            hold_tail  <= 1'b0;
            in_pkt     <= 1'b0;
            frame_err  <= 1'b0;
            ll_src_rdy <= 1'b0;
            ll_data    <= '0;
            ll_sof     <= 1'b0;
            ll_eof     <= 1'b0;
            ll_error   <= 1'b0;
        end else if (clear) begin
            state      <= EMPTY;
            hold_lo    <= '0;
            hold_eof   <= 1'b0;
            hold_tail  <= 1'b0;
            in_pkt     <= 1'b0;
            frame_err  <= 1'b0;
            ll_src_rdy <= 1'b0;
            ll_data    <= '0;
            ll_sof     <= 1'b0;
            ll_eof     <= 1'b0;
            ll_error   <= 1'b0;
        end else begin
            in_pkt    <= in_pkt_nxt_c;
            frame_err <= orphan_c | missing_eof_c;
            if (accept_c) begin
                hold_lo   <= in_word.lo;
                hold_eof  <= in_word.eof;
                hold_tail <= in_word.eof & in_word.occ;
                if (orphan_c && DROP_EN) begin
                    state      <= DROP;
                    ll_src_rdy <= 1'b0;
                    ll_data    <= '0;
                    ll_sof     <= 1'b0;
                    ll_eof     <= 1'b0;
                    ll_error   <= 1'b0;
                end else begin
                    state      <= HI;
                    ll_src_rdy <= 1'b1;
                    ll_data    <= in_word.hi;
                    ll_sof     <= in_word.sof;
                    ll_eof     <= in_word.eof & in_word.occ;
                    ll_error   <= orphan_c;
                end
            end else begin
                case (state)
                    EMPTY: begin
                        state <= EMPTY;
                    end
                    HI: begin
                        if (xfer_c) begin
                            if (hold_tail) begin
                                state      <= EMPTY;
                                ll_src_rdy <= 1'b0;
                                ll_data    <= '0;
                                ll_sof     <= 1'b0;
                                ll_eof     <= 1'b0;
                                ll_error   <= 1'b0;
                            end else begin
                                state   <= LO;
                                ll_data <= hold_lo;
                                ll_sof  <= 1'b0;
                                ll_eof  <= hold_eof;
                            end
                        end
                    end
                    LO: begin
                        if (xfer_c) begin
                            state      <= EMPTY;
                            ll_src_rdy <= 1'b0;
                            ll_data    <= '0;
                            ll_sof     <= 1'b0;
                            ll_eof     <= 1'b0;
                            ll_error   <= 1'b0;
                        end
                    end
                    DROP: begin
                        state <= EMPTY;
                    end
                endcase
            end
        end
    end

    // Saturating framing-violation counter; survives a synchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_count <= '0;
        end else if (!clear && (orphan_c || missing_eof_c) && !(&err_count)) begin
            err_count <= err_count + CNT_WIDTH'(1);
        end
    end

`ifdef FIFO19_TO_LL8_STATS_EN
    // Emitted packet and byte statistics; both wrap and only reset_n clears them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pkt_count  <= '0;
            byte_count <= '0;
        end else if (xfer_c) begin
            byte_count <= byte_count + BYTE_CNT_W'(1);
            if (ll_eof) begin
                pkt_count <= pkt_count + CNT_WIDTH'(1);
            end
        end
    end
`else
    assign pkt_count  = '0;
    assign byte_count = BYTE_CNT_W'(0);
`endif

endmodule

// File: tb/tb_fifo19_to_ll8.sv
// Scoreboard bench for fifo19_to_ll8: instance A drops orphans, instance B passes them
// flagged and uses a 2-bit error counter so saturation is reachable.
module tb_fifo19_to_ll8;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, clear, ll_dst_rdy, src_a, src_b;
    logic [18:0] f19_data;

    logic        dst_a, sof_a, eof_a, err_a, srdy_a, fe_a;
    logic [7:0]  data_a;
    logic [15:0] ec_a, pc_a;
    logic [31:0] bc_a;

    logic        dst_b, sof_b, eof_b, err_b, srdy_b, fe_b;
    logic [7:0]  data_b;
    logic [1:0]  ec_b, pc_b;
    logic [31:0] bc_b;

    fifo19_to_ll8 #(.DROP_ORPHANS(1), .CNT_WIDTH(16)) dut_a (
        .clk(clk), .reset_n(reset_n), .clear(clear),
        .f19_data(f19_data), .f19_src_rdy_i(src_a), .f19_dst_rdy_o(dst_a),
        .ll_data(data_a), .ll_sof(sof_a), .ll_eof(eof_a), .ll_error(err_a),
        .ll_src_rdy(srdy_a), .ll_dst_rdy(ll_dst_rdy), .frame_err(fe_a),
        .err_count(ec_a), .pkt_count(pc_a), .byte_count(bc_a)
    );

    fifo19_to_ll8 #(.DROP_ORPHANS(0), .CNT_WIDTH(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .clear(clear),
        .f19_data(f19_data), .f19_src_rdy_i(src_b), .f19_dst_rdy_o(dst_b),
        .ll_data(data_b), .ll_sof(sof_b), .ll_eof(eof_b), .ll_error(err_b),
        .ll_src_rdy(srdy_b), .ll_dst_rdy(ll_dst_rdy), .frame_err(fe_b),
        .err_count(ec_b), .pkt_count(pc_b), .byte_count(bc_b)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       s;
        logic       e;
        logic       x;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   xfer_cyc_a[$];
    int   checks = 0;
    int   errors = 0;
    int   fe_a_n = 0;
    int   fe_b_n = 0;
    int   cyc = 0;
    exp_t sv_a, sv_b, got;
    bit   stl_a = 0;
    bit   stl_b = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [18:0] wd(input bit occ, input bit eof, input bit sof,
                                       input logic [7:0] hi, input logic [7:0] lo);
        return {occ, eof, sof, hi, lo};
    endfunction

    function automatic exp_t eb(input logic [7:0] d, input bit s, input bit e, input bit x);
        return {d, s, e, x};
    endfunction

    always @(posedge clk) cyc++;

    // Monitor A: stability while stalled, scoreboard pop on every transfer, frame_err pulse count.
    always @(negedge clk) begin
        if (!reset_n || clear) begin
            stl_a = 1'b0;
        end else begin
            got = {data_a, sof_a, eof_a, err_a};
            if (stl_a) chk("stall_hold_a", 32'({srdy_a, got}), 32'({1'b1, sv_a}));
            if (srdy_a && ll_dst_rdy) begin
                xfer_cyc_a.push_back(cyc);
                if (q_a.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_byte_a: got %0h expected none", got);
                end else begin
                    chk("byte_a", 32'(got), 32'(q_a.pop_front()));
                end
            end
            stl_a = srdy_a && !ll_dst_rdy;
            sv_a  = got;
            if (fe_a) fe_a_n++;
        end
    end

    // Monitor B: same checks for the pass-through-orphans instance.
    always @(negedge clk) begin
        if (!reset_n || clear) begin
            stl_b = 1'b0;
        end else begin
            if (stl_b) chk("stall_hold_b", 32'({srdy_b, data_b, sof_b, eof_b, err_b}), 32'({1'b1, sv_b}));
            if (srdy_b && ll_dst_rdy) begin
                if (q_b.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_byte_b: got %0h expected none", {data_b, sof_b, eof_b, err_b});
                end else begin
                    chk("byte_b", 32'({data_b, sof_b, eof_b, err_b}), 32'(q_b.pop_front()));
                end
            end
            stl_b = srdy_b && !ll_dst_rdy;
            sv_b  = {data_b, sof_b, eof_b, err_b};
            if (fe_b) fe_b_n++;
        end
    end

    task automatic send(input bit sel, input logic [18:0] w);
        bit acc = 1'b0;
        int n = 0;
        f19_data = w;
        if (sel) src_b = 1'b1; else src_a = 1'b1;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = sel ? dst_b : dst_a;
            @(posedge clk);
            #1;
            n++;
        end
        src_a = 1'b0;
        src_b = 1'b0;
        if (!acc) begin
            checks++; errors++;
            $display("FAIL send_timeout: got no handshake expected f19_dst_rdy_o=1");
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got %0d/%0d bytes pending expected 0", q_a.size(), q_b.size());
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; clear = 1'b0; src_a = 1'b0; src_b = 1'b0;
        ll_dst_rdy = 1'b1; f19_data = '0;
        #1;
        chk("rst_srdy_a", 32'(srdy_a), 32'd0);
        chk("rst_fe_a",   32'(fe_a),   32'd0);
        chk("rst_ec_a",   32'(ec_a),   32'd0);
        chk("rst_pc_a",   32'(pc_a),   32'd0);
        chk("rst_bc_a",   bc_a,        32'd0);
        chk("rst_b",      32'({srdy_b, ec_b, pc_b}), 32'd0);
        chk("rst_bc_b",   bc_b,        32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // 1: three-word packet, full throughput
        xfer_cyc_a.delete();
        q_a.push_back(eb(8'hA1, 1, 0, 0)); q_a.push_back(eb(8'hA2, 0, 0, 0));
        q_a.push_back(eb(8'hA3, 0, 0, 0)); q_a.push_back(eb(8'hA4, 0, 0, 0));
        q_a.push_back(eb(8'hA5, 0, 0, 0)); q_a.push_back(eb(8'hA6, 0, 1, 0));
        send(0, wd(0, 0, 1, 8'hA1, 8'hA2));
        send(0, wd(0, 0, 0, 8'hA3, 8'hA4));
        send(0, wd(0, 1, 0, 8'hA5, 8'hA6));
        drain();
        chk("t1_nbytes", 32'(xfer_cyc_a.size()), 32'd6);
        if (xfer_cyc_a.size() == 6) chk("t1_span", 32'(xfer_cyc_a[5] - xfer_cyc_a[0]), 32'd5);
        chk("t1_fe", 32'(fe_a_n), 32'd0);

        // 2: single-byte packet immediately followed by a two-byte packet
        q_a.push_back(eb(8'h5A, 1, 1, 0));
        q_a.push_back(eb(8'hB1, 1, 0, 0)); q_a.push_back(eb(8'hB2, 0, 1, 0));
        send(0, wd(1, 1, 1, 8'h5A, 8'hC3));
        send(0, wd(0, 1, 1, 8'hB1, 8'hB2));
        drain();
        chk("t2_fe", 32'(fe_a_n), 32'd0);

        // 3: downstream stalls during a four-byte packet
        q_a.push_back(eb(8'hC1, 1, 0, 0)); q_a.push_back(eb(8'hC2, 0, 0, 0));
        q_a.push_back(eb(8'hC3, 0, 0, 0)); q_a.push_back(eb(8'hC4, 0, 1, 0));
        fork
            begin
                send(0, wd(0, 0, 1, 8'hC1, 8'hC2));
                send(0, wd(0, 1, 0, 8'hC3, 8'hC4));
            end
            begin
                logic [7:0] pat;
                pat = 8'b1101_0011;
                for (int i = 0; i < 8; i++) begin
                    ll_dst_rdy = pat[i];
                    @(posedge clk);
                    #1;
                end
                ll_dst_rdy = 1'b1;
            end
        join
        drain();
        chk("t3_fe", 32'(fe_a_n), 32'd0);

        // 4: orphan dropped by A, passed flagged by B; B counter saturates
        chk("t4_ec_a_before", 32'(ec_a), 32'd0);
        send(0, wd(0, 1, 0, 8'h11, 8'h22));
        drain();
        chk("t4_fe_a", 32'(fe_a_n), 32'd1);
        chk("t4_ec_a", 32'(ec_a), 32'd1);
        q_b.push_back(eb(8'h11, 0, 0, 1)); q_b.push_back(eb(8'h22, 0, 1, 1));
        send(1, wd(0, 1, 0, 8'h11, 8'h22));
        drain();
        chk("t4_fe_b", 32'(fe_b_n), 32'd1);
        chk("t4_ec_b", 32'(ec_b), 32'd1);
        for (int i = 0; i < 3; i++) begin
            q_b.push_back(eb(8'(8'h60 + 2 * i), 0, 0, 1));
            q_b.push_back(eb(8'(8'h61 + 2 * i), 0, 0, 1));
            send(1, wd(0, 0, 0, 8'(8'h60 + 2 * i), 8'(8'h61 + 2 * i)));
        end
        drain();
        chk("t4_fe_b_sat", 32'(fe_b_n), 32'd4);
        chk("t4_ec_b_sat", 32'(ec_b), 32'd3);

        // 5: missing eof, then async reset with a byte stalled on the output
        q_a.push_back(eb(8'hD1, 1, 0, 0)); q_a.push_back(eb(8'hD2, 0, 0, 0));
        q_a.push_back(eb(8'hE1, 1, 0, 0)); q_a.push_back(eb(8'hE2, 0, 0, 0));
        send(0, wd(0, 0, 1, 8'hD1, 8'hD2));
        send(0, wd(0, 0, 1, 8'hE1, 8'hE2));
        drain();
        chk("t5_fe_a", 32'(fe_a_n), 32'd2);
        chk("t5_ec_a", 32'(ec_a), 32'd2);
        ll_dst_rdy = 1'b0;
        send(0, wd(0, 0, 0, 8'hF1, 8'hF2));
        @(posedge clk); #1;
        chk("t5_stalled_srdy", 32'(srdy_a), 32'd1);
        chk("t5_stalled_data", 32'(data_a), 32'hF1);
        reset_n = 1'b0;
        #1;
        chk("t5_async_srdy", 32'(srdy_a), 32'd0);
        chk("t5_async_ec", 32'(ec_a), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        ll_dst_rdy = 1'b1;
        q_a.push_back(eb(8'h71, 1, 0, 0)); q_a.push_back(eb(8'h72, 0, 1, 0));
        send(0, wd(0, 1, 1, 8'h71, 8'h72));
        drain();
        chk("t5_clean_fe", 32'(fe_a_n), 32'd2);
        chk("t5_clean_ec", 32'(ec_a), 32'd0);

        // 6: statistics over packets of 5, 1 and 8 bytes, then clear behaviour
        pulse_reset();
        q_a.push_back(eb(8'h10, 1, 0, 0)); q_a.push_back(eb(8'h11, 0, 0, 0));
        q_a.push_back(eb(8'h12, 0, 0, 0)); q_a.push_back(eb(8'h13, 0, 0, 0));
        q_a.push_back(eb(8'h14, 0, 1, 0));
        send(0, wd(0, 0, 1, 8'h10, 8'h11));
        send(0, wd(0, 0, 0, 8'h12, 8'h13));
        send(0, wd(1, 1, 0, 8'h14, 8'h00));
        q_a.push_back(eb(8'h20, 1, 1, 0));
        send(0, wd(1, 1, 1, 8'h20, 8'h00));
        for (int i = 0; i < 4; i++) begin
            q_a.push_back(eb(8'(8'h30 + 2 * i), (i == 0), 1'b0, 1'b0));
            q_a.push_back(eb(8'(8'h31 + 2 * i), 1'b0, (i == 3), 1'b0));
            send(0, wd(1'b0, (i == 3), (i == 0), 8'(8'h30 + 2 * i), 8'(8'h31 + 2 * i)));
        end
        drain();
`ifdef FIFO19_TO_LL8_STATS_EN
        chk("t6_pkt_count",  32'(pc_a), 32'd3);
        chk("t6_byte_count", bc_a,      32'd14);
`else
        chk("t6_pkt_count",  32'(pc_a), 32'd0);
        chk("t6_byte_count", bc_a,      32'd0);
`endif
        chk("t6_ec_a", 32'(ec_a), 32'd0);

        q_a.push_back(eb(8'h40, 1, 0, 0)); q_a.push_back(eb(8'h41, 0, 0, 0));
        send(0, wd(0, 0, 1, 8'h40, 8'h41));
        drain();
        ll_dst_rdy = 1'b0;
        send(0, wd(0, 0, 0, 8'h42, 8'h43));
        chk("t6_held_srdy", 32'(srdy_a), 32'd1);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        chk("t6_clear_srdy", 32'(srdy_a), 32'd0);
        ll_dst_rdy = 1'b1;
        send(0, wd(0, 0, 0, 8'h50, 8'h51));
        drain();
        chk("t6_orphan_after_clear_fe", 32'(fe_a_n), 32'd3);
        chk("t6_orphan_after_clear_ec", 32'(ec_a), 32'd1);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        chk("t6_clear_keeps_ec", 32'(ec_a), 32'd1);
`ifdef FIFO19_TO_LL8_STATS_EN
        chk("t6_clear_keeps_pkt",  32'(pc_a), 32'd3);
        chk("t6_clear_keeps_byte", bc_a,      32'd16);
`else
        chk("t6_clear_keeps_pkt",  32'(pc_a), 32'd0);
        chk("t6_clear_keeps_byte", bc_a,      32'd0);
`endif

        chk("end_q_a", 32'(q_a.size()), 32'd0);
        chk("end_q_b", 32'(q_b.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
